// File: rtl/bp_cce_dir_read_sequencer_if.sv
// rtl/bp_cce_dir_read_sequencer_if.sv - request, directory RAM and sharers-result signals of the directory read sequencer
interface bp_cce_dir_read_sequencer_if #(
    parameter int num_lce_p          = 4,
    parameter int sets_p             = 8,
    parameter int assoc_p            = 2,
    parameter int tag_width_p        = 8,
    parameter int tag_sets_per_row_p = 2,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + 3)
);
    localparam int rows_per_set_lp = (num_lce_p + tag_sets_per_row_p - 1) / tag_sets_per_row_p;
    localparam int lg_rows_lp      = (sets_p * rows_per_set_lp > 1) ? $clog2(sets_p * rows_per_set_lp) : 1;
    localparam int lg_sets_lp      = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam int lg_assoc_lp     = (assoc_p > 1) ? $clog2(assoc_p) : 1;
    localparam int lg_num_lce_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int state_width_lp  = 3;

    logic                                  req_v_i;
    logic                                  req_ready_and_o;
    logic [lg_sets_lp-1:0]                 req_set_i;
    logic [tag_width_p-1:0]                req_tag_i;
    logic                                  ram_v_o;
    logic [lg_rows_lp-1:0]                 ram_addr_o;
    logic [row_width_p-1:0]                ram_data_i;
    logic                                  sharers_v_o;
    logic                                  sharers_yumi_i;
    logic [num_lce_p-1:0]                  sharers_hits_o;
    logic [num_lce_p*lg_assoc_lp-1:0]      sharers_ways_o;
    logic [num_lce_p*state_width_lp-1:0]   sharers_states_o;
    logic                                  owner_v_o;
    logic [lg_num_lce_lp-1:0]              owner_lce_o;

    modport slave (
        input  req_v_i, req_set_i, req_tag_i, ram_data_i, sharers_yumi_i,
        output req_ready_and_o, ram_v_o, ram_addr_o, sharers_v_o,
               sharers_hits_o, sharers_ways_o, sharers_states_o, owner_v_o, owner_lce_o
    );

    modport master (
        output req_v_i, req_set_i, req_tag_i, ram_data_i, sharers_yumi_i,
        input  req_ready_and_o, ram_v_o, ram_addr_o, sharers_v_o,
               sharers_hits_o, sharers_ways_o, sharers_states_o, owner_v_o, owner_lce_o
    );
endinterface

// File: rtl/bp_cce_dir_read_sequencer.sv
// rtl/bp_cce_dir_read_sequencer.sv - walks every directory row of a set and gathers per-LCE hit/way/state
// Optional owner output is built only when BP_CCE_DIR_SEQ_OWNER_EN is defined.

// Bit 1 marks the owning states (E, F, M, O).
typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
} bp_coh_states_e;

module bp_cce_dir_read_sequencer #(
    parameter int num_lce_p          = 4,
    parameter int sets_p             = 8,
    parameter int assoc_p            = 2,
    parameter int tag_width_p        = 8,
    parameter int tag_sets_per_row_p = 2,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + $bits(bp_coh_states_e))
) (
    input logic clk_i,
    input logic reset_i,
    bp_cce_dir_read_sequencer_if.slave bus
);
    localparam int rows_per_set_lp = (num_lce_p + tag_sets_per_row_p - 1) / tag_sets_per_row_p;
    localparam int lg_rows_lp      = (sets_p * rows_per_set_lp > 1) ? $clog2(sets_p * rows_per_set_lp) : 1;
    localparam int lg_sets_lp      = (sets_p > 1) ? $clog2(sets_p) : 1;
    localparam int lg_assoc_lp     = (assoc_p > 1) ? $clog2(assoc_p) : 1;
    localparam int lg_num_lce_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1;
    localparam int sw_lp           = $bits(bp_coh_states_e);
    localparam int cnt_width_lp    = $clog2(rows_per_set_lp) + 1;

    typedef enum logic [1:0] {e_ready, e_read, e_done} state_e;

    state_e                             state_r;
    logic [lg_sets_lp-1:0]              set_r;
    logic [tag_width_p-1:0]             tag_r;
    logic [cnt_width_lp-1:0]            row_cnt_r;
    logic [cnt_width_lp-1:0]            capture_row_r;
    logic                               capture_v_r;
    logic                               sharers_v_r;
    logic [num_lce_p-1:0]               hits_r;
    logic [num_lce_p*lg_assoc_lp-1:0]   ways_r;
    logic [num_lce_p*sw_lp-1:0]         states_r;

    logic [tag_sets_per_row_p-1:0]             chk_row_v;
    logic [tag_sets_per_row_p-1:0]             chk_hit;
    logic [tag_sets_per_row_p*lg_assoc_lp-1:0] chk_way;
    logic [tag_sets_per_row_p*sw_lp-1:0]       chk_state;

    // Tag sets past num_lce_p in the last row are padding and never report.
    always_comb begin
        chk_row_v = '0;
        for (int i = 0; i < tag_sets_per_row_p; i++)
            chk_row_v[i] = (int'(capture_row_r) * tag_sets_per_row_p + i < num_lce_p);
    end

    bp_cce_dir_tag_checker #(
        .tag_sets_per_row_p(tag_sets_per_row_p),
        .assoc_p           (assoc_p),
        .tag_width_p       (tag_width_p),
        .row_width_p       (row_width_p)
    ) tag_checker (
        .row_i  (bus.ram_data_i),
        .row_v_i(chk_row_v),
        .tag_i  (tag_r),
        .hit_o  (chk_hit),
        .way_o  (chk_way),
        .state_o(chk_state)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= e_ready;
            set_r         <= '0;
            tag_r         <= '0;
            row_cnt_r     <= '0;
            capture_row_r <= '0;
            capture_v_r   <= 1'b0;
            sharers_v_r   <= 1'b0;
            hits_r        <= '0;
            ways_r        <= '0;
            states_r      <= {num_lce_p{e_COH_I}};
        end else begin
            capture_v_r <= 1'b0;
            if (capture_v_r) begin
                for (int j = 0; j < num_lce_p; j++) begin
                    if (capture_row_r == cnt_width_lp'(j / tag_sets_per_row_p)) begin
                        hits_r[j]                       <= chk_hit[j % tag_sets_per_row_p];
                        ways_r[j*lg_assoc_lp +: lg_assoc_lp] <= chk_way[(j % tag_sets_per_row_p)*lg_assoc_lp +: lg_assoc_lp];
                        states_r[j*sw_lp +: sw_lp]      <= chk_state[(j % tag_sets_per_row_p)*sw_lp +: sw_lp];
                    end
                end
            end
            unique case (state_r)
                e_ready: begin
                    if (bus.req_v_i) begin
                        set_r     <= bus.req_set_i;
                        tag_r     <= bus.req_tag_i;
                        row_cnt_r <= '0;
                        hits_r    <= '0;
                        ways_r    <= '0;
                        states_r  <= {num_lce_p{e_COH_I}};
                        state_r   <= e_read;
                    end
                end
                e_read: begin
                    capture_v_r   <= 1'b1;
                    capture_row_r <= row_cnt_r;
                    row_cnt_r     <= row_cnt_r + 1'b1;
                    if (row_cnt_r == cnt_width_lp'(rows_per_set_lp - 1))
                        state_r <= e_done;
                end
                e_done: begin
                    // The last row is still being written on the first e_done cycle.
                    if (capture_v_r)
                        sharers_v_r <= 1'b1;
                    if (sharers_v_r && bus.sharers_yumi_i) begin
                        sharers_v_r <= 1'b0;
                        state_r     <= e_ready;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    assign bus.req_ready_and_o  = (state_r == e_ready) & ~reset_i;
    assign bus.ram_v_o          = (state_r == e_read) & ~reset_i;
    assign bus.ram_addr_o       = lg_rows_lp'(set_r) * lg_rows_lp'(rows_per_set_lp) + lg_rows_lp'(row_cnt_r);
    assign bus.sharers_v_o      = sharers_v_r;
    assign bus.sharers_hits_o   = hits_r;
    assign bus.sharers_ways_o   = ways_r;
    assign bus.sharers_states_o = states_r;

`ifdef BP_CCE_DIR_SEQ_OWNER_EN
    logic                     owner_found;
    logic [lg_num_lce_lp-1:0] owner_idx;

    always_comb begin
        owner_found = 1'b0;
        owner_idx   = '0;
        for (int j = num_lce_p - 1; j >= 0; j--) begin
            if (states_r[j*sw_lp + 1]) begin
                owner_found = 1'b1;
                owner_idx   = lg_num_lce_lp'(j);
            end
        end
    end

    assign bus.owner_v_o   = sharers_v_r & owner_found;
    assign bus.owner_lce_o = sharers_v_r ? owner_idx : '0;
`else
    assign bus.owner_v_o   = 1'b0;
    assign bus.owner_lce_o = '0;
`endif

    req_set_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        (bus.req_v_i && bus.req_ready_and_o) |-> (32'(bus.req_set_i) < sets_p));

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.sharers_yumi_i |-> sharers_v_r);
endmodule

// Entry layout within a row: tag set i, way w at index i*assoc_p+w, each entry {tag, state}.
module bp_cce_dir_tag_checker #(
    parameter int tag_sets_per_row_p = 2,
    parameter int assoc_p            = 2,
    parameter int tag_width_p        = 8,
    parameter int row_width_p        = tag_sets_per_row_p * assoc_p * (tag_width_p + $bits(bp_coh_states_e)),
    localparam int lg_assoc_lp       = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int sw_lp             = $bits(bp_coh_states_e),
    localparam int entry_width_lp    = tag_width_p + sw_lp
) (
    input  logic [row_width_p-1:0]                    row_i,
    input  logic [tag_sets_per_row_p-1:0]             row_v_i,
    input  logic [tag_width_p-1:0]                    tag_i,
    output logic [tag_sets_per_row_p-1:0]             hit_o,
    output logic [tag_sets_per_row_p*lg_assoc_lp-1:0] way_o,
    output logic [tag_sets_per_row_p*sw_lp-1:0]       state_o
);
    // Ways are scanned high to low so the lowest matching way wins.
    always_comb begin
        hit_o   = '0;
        way_o   = '0;
        state_o = {tag_sets_per_row_p{e_COH_I}};
        for (int i = 0; i < tag_sets_per_row_p; i++) begin
            for (int w = assoc_p - 1; w >= 0; w--) begin
                if (row_v_i[i]
                    && row_i[(i*assoc_p + w)*entry_width_lp + sw_lp +: tag_width_p] == tag_i
                    && row_i[(i*assoc_p + w)*entry_width_lp +: sw_lp] != e_COH_I) begin
                    hit_o[i]                             = 1'b1;
                    way_o[i*lg_assoc_lp +: lg_assoc_lp]  = lg_assoc_lp'(w);
                    state_o[i*sw_lp +: sw_lp]            = row_i[(i*assoc_p + w)*entry_width_lp +: sw_lp];
                end
            end
        end
    end
endmodule

// File: tb/tb_bp_cce_dir_read_sequencer.sv
// tb/tb_bp_cce_dir_read_sequencer.sv - directed checks of the directory read sequencer (4-LCE and 3-LCE builds)
module tb_bp_cce_dir_read_sequencer;
    localparam logic [2:0] st_i = 3'b000;
    localparam logic [2:0] st_s = 3'b001;
    localparam logic [2:0] st_e = 3'b010;
    localparam logic [2:0] st_m = 3'b110;
    localparam logic [2:0] st_o = 3'b111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_cce_dir_read_sequencer_if #(.num_lce_p(4), .sets_p(8), .assoc_p(2), .tag_width_p(8),
        .tag_sets_per_row_p(2), .row_width_p(44)) if4 ();
    bp_cce_dir_read_sequencer_if #(.num_lce_p(3), .sets_p(8), .assoc_p(2), .tag_width_p(8),
        .tag_sets_per_row_p(2), .row_width_p(44)) if3 ();

    bp_cce_dir_read_sequencer #(.num_lce_p(4), .sets_p(8), .assoc_p(2), .tag_width_p(8),
        .tag_sets_per_row_p(2), .row_width_p(44)) dut4 (.clk_i(clk), .reset_i(reset), .bus(if4));
    bp_cce_dir_read_sequencer #(.num_lce_p(3), .sets_p(8), .assoc_p(2), .tag_width_p(8),
        .tag_sets_per_row_p(2), .row_width_p(44)) dut3 (.clk_i(clk), .reset_i(reset), .bus(if3));

    logic [43:0] mem [16];

    always @(posedge clk) begin
        if (if4.ram_v_o) if4.ram_data_i <= mem[if4.ram_addr_o];
        if (if3.ram_v_o) if3.ram_data_i <= mem[if3.ram_addr_o];
    end

    function automatic logic [10:0] ent(input logic [7:0] tag, input logic [2:0] st);
        return {tag, st};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with dut4 idle; returns at the negedge of cycle 4.
    task automatic lookup4(input logic [2:0] set, input logic [7:0] tag);
        check("lk_ready", if4.req_ready_and_o, 1);
        if4.req_v_i   = 1'b1;
        if4.req_set_i = set;
        if4.req_tag_i = tag;
        @(negedge clk);
        if4.req_v_i = 1'b0;
        check("lk_ram_v_c1", if4.ram_v_o, 1);
        check("lk_addr_c1", if4.ram_addr_o, {set, 1'b0});
        @(negedge clk);
        check("lk_ram_v_c2", if4.ram_v_o, 1);
        check("lk_addr_c2", if4.ram_addr_o, {set, 1'b1});
        @(negedge clk);
        check("lk_ram_v_c3", if4.ram_v_o, 0);
        check("lk_sv_c3", if4.sharers_v_o, 0);
        @(negedge clk);
        check("lk_sv_c4", if4.sharers_v_o, 1);
    endtask

    task automatic yumi4();
        if4.sharers_yumi_i = 1'b1;
        @(negedge clk);
        if4.sharers_yumi_i = 1'b0;
        check("yumi_sv", if4.sharers_v_o, 0);
        check("yumi_ready", if4.req_ready_and_o, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 16; r++) mem[r] = '0;
        mem[6][0  +: 11] = ent(8'h5b, st_i);
        mem[6][11 +: 11] = ent(8'h11, st_m);
        mem[6][33 +: 11] = ent(8'h5a, st_s);
        mem[7][0  +: 11] = ent(8'h5a, st_m);
        mem[7][11 +: 11] = ent(8'h33, st_s);
        mem[7][22 +: 11] = ent(8'h44, st_e);
        mem[7][33 +: 11] = ent(8'h5a, st_i);
        mem[2][0  +: 11] = ent(8'h77, st_s);
        mem[3][33 +: 11] = ent(8'h77, st_o);
        mem[1][22 +: 11] = ent(8'h5a, st_m);

        if4.req_v_i = 1'b0; if4.req_set_i = '0; if4.req_tag_i = '0; if4.sharers_yumi_i = 1'b0;
        if3.req_v_i = 1'b0; if3.req_set_i = '0; if3.req_tag_i = '0; if3.sharers_yumi_i = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready_hi", if4.req_ready_and_o, 0);
        check("rst_ram_v_hi", if4.ram_v_o, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", if4.req_ready_and_o, 1);
        check("idle_sv", if4.sharers_v_o, 0);
        check("idle_hits", if4.sharers_hits_o, 0);
        check("idle_ways", if4.sharers_ways_o, 0);
        check("idle_states", if4.sharers_states_o, 0);
        check("idle_owner_v", if4.owner_v_o, 0);
        check("idle_owner_lce", if4.owner_lce_o, 0);
        check("idle3_ready", if3.req_ready_and_o, 1);
        repeat (3) begin
            @(negedge clk);
            check("idle_ram_v", if4.ram_v_o, 0);
        end

        lookup4(3'd3, 8'h5a);
        check("hit_hits", if4.sharers_hits_o, 4'b0110);
        check("hit_ways", if4.sharers_ways_o, 4'b0010);
        check("hit_states", if4.sharers_states_o, 12'h188);

        // Held result: a competing request must wait for yumi.
        for (int k = 0; k < 5; k++) begin
            if4.req_v_i   = 1'b1;
            if4.req_set_i = 3'd1;
            if4.req_tag_i = 8'h77;
            @(negedge clk);
            check("hold_sv", if4.sharers_v_o, 1);
            check("hold_hits", if4.sharers_hits_o, 4'b0110);
            check("hold_states", if4.sharers_states_o, 12'h188);
            check("hold_ready", if4.req_ready_and_o, 0);
            check("hold_ram_v", if4.ram_v_o, 0);
        end
        if4.sharers_yumi_i = 1'b1;
        @(negedge clk);
        if4.sharers_yumi_i = 1'b0;
        check("rel_sv", if4.sharers_v_o, 0);
        check("rel_ready", if4.req_ready_and_o, 1);
        @(negedge clk);
        if4.req_v_i = 1'b0;
        check("own_ram_v_c1", if4.ram_v_o, 1);
        check("own_addr_c1", if4.ram_addr_o, 2);
        @(negedge clk);
        check("own_addr_c2", if4.ram_addr_o, 3);
        @(negedge clk);
        check("own_sv_c3", if4.sharers_v_o, 0);
        @(negedge clk);
        check("own_sv_c4", if4.sharers_v_o, 1);
        check("own_hits", if4.sharers_hits_o, 4'b1001);
        check("own_ways", if4.sharers_ways_o, 4'b1000);
        check("own_states", if4.sharers_states_o, 12'he01);
`ifdef BP_CCE_DIR_SEQ_OWNER_EN
        check("own_owner_v", if4.owner_v_o, 1);
        check("own_owner_lce", if4.owner_lce_o, 3);
`else
        check("own_owner_v", if4.owner_v_o, 0);
        check("own_owner_lce", if4.owner_lce_o, 0);
`endif
        yumi4();

        lookup4(3'd3, 8'h5b);
        check("miss_hits", if4.sharers_hits_o, 0);
        check("miss_ways", if4.sharers_ways_o, 0);
        check("miss_states", if4.sharers_states_o, 0);
        yumi4();

        // Reset lands in the cycle of the second RAM read.
        if4.req_v_i   = 1'b1;
        if4.req_set_i = 3'd3;
        if4.req_tag_i = 8'h5a;
        @(negedge clk);
        if4.req_v_i = 1'b0;
        check("mid_ram_v_c1", if4.ram_v_o, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_ram_v_rst", if4.ram_v_o, 0);
        check("mid_ready_rst", if4.req_ready_and_o, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_sv", if4.sharers_v_o, 0);
            check("mid_ram_v", if4.ram_v_o, 0);
        end
        lookup4(3'd3, 8'h5a);
        check("post_hits", if4.sharers_hits_o, 4'b0110);
        check("post_ways", if4.sharers_ways_o, 4'b0010);
        check("post_states", if4.sharers_states_o, 12'h188);
        yumi4();

        // Three LCEs: the padding tag set in the last row matches but must not report.
        check("pad_ready", if3.req_ready_and_o, 1);
        if3.req_v_i   = 1'b1;
        if3.req_set_i = 3'd0;
        if3.req_tag_i = 8'h5a;
        @(negedge clk);
        if3.req_v_i = 1'b0;
        check("pad_addr_c1", if3.ram_addr_o, 0);
        repeat (3) @(negedge clk);
        check("pad_sv", if3.sharers_v_o, 1);
        check("pad_hits", if3.sharers_hits_o, 3'b000);
        check("pad_states", if3.sharers_states_o, 0);
        if3.sharers_yumi_i = 1'b1;
        @(negedge clk);
        if3.sharers_yumi_i = 1'b0;
        check("pad_yumi_ready", if3.req_ready_and_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
